ariscv_ctrl_ring: RTL and testbench

- Clocked, parametrised model of the async control-path token ring, for FPGA prototyping and cycle-level study of link delays.
- NUM_STAGES half-buffer stages in a closed ring carry TOKENS tokens. Each inter-stage link has a runtime-programmable delay.
- A stage emits a one-cycle o_aclk pulse when a token arrives. This generalises the fixed 6-stage, parameter-delay control path to N stages, T tokens, runtime delays and an enable.

---
 rtl/ariscv_ctrl_pkg.sv | 12 +
 rtl/ariscv_ctrl_stage.sv | 59 +++++
 rtl/ariscv_ctrl_ring.sv | 65 ++++++
 tb/tb_ariscv_ctrl_ring.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariscv_ctrl_pkg.sv
// Shared constants, types and ring-index helper for the clocked async control-path token ring.
package ariscv_ctrl_pkg;

  localparam int DELAY_W_DEF = 4;

  typedef logic [DELAY_W_DEF-1:0] delay_t;

  function automatic int idx_next(input int k, input int n);
    return (k + 1) % n;
  endfunction

endpackage

// File: rtl/ariscv_ctrl_stage.sv
// One half-buffer ring stage: full flag, hold-delay down-counter and a one-cycle arrival pulse.
module ariscv_ctrl_stage
  import ariscv_ctrl_pkg::*;
#(
  parameter int DELAY_W   = DELAY_W_DEF,
  parameter bit INIT_FULL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_async_n,
  input  logic               en_i,
  input  logic               in_valid_i,
  input  logic               next_full_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               full_o,
  output logic               aclk_o,
  output logic               send_o
);

  logic               full_q, full_d;
  logic               aclk_q, aclk_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;

  // Successor occupancy is the pre-edge value, so a stage vacated on this
  // edge is never refilled on the same edge.
  assign send_o = en_i & full_q & (cnt_q == '0) & ~next_full_i;
  assign full_o = full_q;
  assign aclk_o = aclk_q & en_i;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    full_d = full_q;
    cnt_d  = cnt_q;
    aclk_d = 1'b0;
    if (in_valid_i) begin
      full_d = 1'b1;
      cnt_d  = delay_i;
      aclk_d = 1'b1;
    end else if (send_o) begin
      full_d = 1'b0;
    end else if (en_i && full_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments and take the async reset;
  // blocking here would create ordering races between stages.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      full_q <= INIT_FULL;
      cnt_q  <= '0;
      aclk_q <= 1'b0;
    end else begin
      full_q <= full_d;
      cnt_q  <= cnt_d;
      aclk_q <= aclk_d;
    end
  end

endmodule

// File: rtl/ariscv_ctrl_ring.sv
// Closed ring of NUM_STAGES half-buffer stages carrying TOKENS tokens with programmable link delays.
// Optional lap counter on stage 0 arrivals: define ARISCV_CTRL_LAP_CNT_EN to add o_laps.
module ariscv_ctrl_ring
  import ariscv_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int TOKENS     = 1,
  parameter int DELAY_W    = DELAY_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_async_n,
  input  logic                          i_en,
  input  logic [NUM_STAGES*DELAY_W-1:0] i_delay,
  output logic [NUM_STAGES-1:0]         o_aclk,
  output logic [NUM_STAGES-1:0]         o_full
`ifdef ARISCV_CTRL_LAP_CNT_EN
  ,
  output logic [31:0]                   o_laps
`endif
);

  logic [NUM_STAGES-1:0] send;

  if (NUM_STAGES < 2 || TOKENS < 1 || TOKENS >= NUM_STAGES) begin : g_bad_params
    $error("ariscv_ctrl_ring: need NUM_STAGES>=2 and 1<=TOKENS<NUM_STAGES");
  end

  // Stage k receives from its predecessor and watches its successor's occupancy.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int NXT = idx_next(k, NUM_STAGES);
    localparam int PRV = (k + NUM_STAGES - 1) % NUM_STAGES;

    ariscv_ctrl_stage #(
      .DELAY_W  (DELAY_W),
      .INIT_FULL(k < TOKENS)
    ) u_stage (
      .clk        (clk),
      .rst_async_n(rst_async_n),
      .en_i       (i_en),
      .in_valid_i (send[PRV]),
      .next_full_i(o_full[NXT]),
      .delay_i    (i_delay[k*DELAY_W +: DELAY_W]),
      .full_o     (o_full[k]),
      .aclk_o     (o_aclk[k]),
      .send_o     (send[k])
    );
  end

`ifdef ARISCV_CTRL_LAP_CNT_EN
  logic [31:0] laps_q;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n)   laps_q <= '0;
    else if (o_aclk[0]) laps_q <= laps_q + 32'd1;
  end

  assign o_laps = laps_q;
`endif

  // Tokens are neither created nor destroyed by any transfer.
  a_token_count : assert property (@(posedge clk) disable iff (!rst_async_n)
                                   $countones(o_full) == TOKENS)
    else $error("ariscv_ctrl_ring: token count changed");

endmodule

// File: tb/tb_ariscv_ctrl_ring.sv
// Bench for ariscv_ctrl_ring: a 6-stage/1-token ring and a 4-stage/3-token ring against a token-timing model.
module tb_ariscv_ctrl_ring;
  import ariscv_ctrl_pkg::*;

  localparam int NA = 6;
  localparam int TA = 1;
  localparam int NB = 4;
  localparam int TB = 3;
  localparam int DW = DELAY_W_DEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_async_n = 1'b0;
  logic             en_a = 1'b1, en_b = 1'b1;
  logic [NA*DW-1:0] delay_a = '0;
  logic [NB*DW-1:0] delay_b = '0;
  logic [NA-1:0]    aclk_a, full_a;
  logic [NB-1:0]    aclk_b, full_b;
`ifdef ARISCV_CTRL_LAP_CNT_EN
  logic [31:0]      laps_a, laps_b;
`endif

  ariscv_ctrl_ring #(.NUM_STAGES(NA), .TOKENS(TA), .DELAY_W(DW)) u_dut_a (
    .clk        (clk),
    .rst_async_n(rst_async_n),
    .i_en       (en_a),
    .i_delay    (delay_a),
    .o_aclk     (aclk_a),
    .o_full     (full_a)
`ifdef ARISCV_CTRL_LAP_CNT_EN
    ,
    .o_laps     (laps_a)
`endif
  );

  ariscv_ctrl_ring #(.NUM_STAGES(NB), .TOKENS(TB), .DELAY_W(DW)) u_dut_b (
    .clk        (clk),
    .rst_async_n(rst_async_n),
    .i_en       (en_b),
    .i_delay    (delay_b),
    .o_aclk     (aclk_b),
    .o_full     (full_b)
`ifdef ARISCV_CTRL_LAP_CNT_EN
    ,
    .o_laps     (laps_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Token-timing model: each held token carries the enabled-edge index from which it may leave.
  int          m_n   [2] = '{NA, NB};
  int          m_tok [2] = '{TA, TB};
  bit          m_full [2][NA];
  bit          m_pulse[2][NA];
  int          m_rdy  [2][NA];
  int          m_t    [2];
  logic [31:0] m_laps [2];

  function automatic void model_reset(input int d);
    for (int k = 0; k < NA; k++) begin
      m_full[d][k]  = (k < m_tok[d]);
      m_pulse[d][k] = 1'b0;
      m_rdy[d][k]   = 1;
    end
    m_t[d]    = 0;
    m_laps[d] = '0;
  endfunction

  function automatic void model_edge(input int d, input bit en, input logic [NA*DW-1:0] dl);
    bit leave[NA];
    int j;
    for (int k = 0; k < NA; k++) begin
      m_pulse[d][k] = 1'b0;
      leave[k]      = 1'b0;
    end
    if (!en) return;
    m_t[d]++;
    for (int k = 0; k < m_n[d]; k++)
      leave[k] = m_full[d][k] && (m_t[d] >= m_rdy[d][k]) && !m_full[d][(k + 1) % m_n[d]];
    for (int k = 0; k < m_n[d]; k++) begin
      if (leave[k]) begin
        j             = (k + 1) % m_n[d];
        m_full[d][k]  = 1'b0;
        m_full[d][j]  = 1'b1;
        m_pulse[d][j] = 1'b1;
        m_rdy[d][j]   = m_t[d] + int'(dl[j*DW +: DW]) + 1;
      end
    end
  endfunction

  function automatic logic [NA-1:0] exp_full(input int d);
    logic [NA-1:0] v = '0;
    for (int k = 0; k < m_n[d]; k++) v[k] = m_full[d][k];
    return v;
  endfunction

  function automatic logic [NA-1:0] exp_aclk(input int d, input bit en);
    logic [NA-1:0] v = '0;
    for (int k = 0; k < m_n[d]; k++) v[k] = m_pulse[d][k] & en;
    return v;
  endfunction

  // One clock: inputs are captured before the edge, model advanced, outputs settle by the negedge.
  task automatic tick();
    bit               ea, eb;
    logic [NA*DW-1:0] da, db;
    ea = en_a;
    eb = en_b;
    da = delay_a;
    db = {{(NA-NB)*DW{1'b0}}, delay_b};
    if (m_pulse[0][0] && ea) m_laps[0] = m_laps[0] + 32'd1;
    if (m_pulse[1][0] && eb) m_laps[1] = m_laps[1] + 32'd1;
    @(posedge clk);
    model_edge(0, ea, da);
    model_edge(1, eb, db);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_async_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_async_n = 1'b1;
    model_reset(0);
    model_reset(1);
  endtask

  task automatic test_reset();
    en_a = 1'b1; en_b = 1'b1; delay_a = '0; delay_b = '0;
    do_reset();
    checks++;
    if (full_a !== 6'b000001) begin errors++; $display("FAIL reset_full_a got=%b want=000001", full_a); end
    checks++;
    if (aclk_a !== '0) begin errors++; $display("FAIL reset_aclk_a got=%b want=0", aclk_a); end
    checks++;
    if (full_b !== 4'b0111) begin errors++; $display("FAIL reset_full_b got=%b want=0111", full_b); end
    checks++;
    if (aclk_b !== '0) begin errors++; $display("FAIL reset_aclk_b got=%b want=0", aclk_b); end
`ifdef ARISCV_CTRL_LAP_CNT_EN
    checks++;
    if (laps_a !== 32'd0) begin errors++; $display("FAIL reset_laps got=%0d want=0", laps_a); end
`endif
  endtask

  task automatic test_ring_zero();
    logic [NA-1:0] want;
    en_a = 1'b1; delay_a = '0;
    do_reset();
    for (int i = 1; i <= 13; i++) begin
      tick();
      want = '0;
      want[i % NA] = 1'b1;
      checks++;
      if (aclk_a !== want || full_a !== want) begin
        errors++;
        $display("FAIL ring_zero cyc=%0d aclk=%b full=%b want=%b", i, aclk_a, full_a, want);
      end
    end
  endtask

  task automatic test_ring_delay2();
    int last[NA];
    int pulses = 0;
    en_a = 1'b1; delay_a = {NA{4'd2}};
    do_reset();
    for (int k = 0; k < NA; k++) last[k] = -1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      checks++;
      if ({full_a, aclk_a} !== {exp_full(0), exp_aclk(0, en_a)}) begin
        errors++;
        $display("FAIL delay2_model cyc=%0d full=%b aclk=%b want full=%b aclk=%b",
                 i, full_a, aclk_a, exp_full(0), exp_aclk(0, en_a));
      end
      for (int k = 0; k < NA; k++) begin
        if (aclk_a[k]) begin
          pulses++;
          if (last[k] >= 0) begin
            checks++;
            if (i - last[k] != 18) begin
              errors++; $display("FAIL delay2_period stage=%0d got=%0d want=18", k, i - last[k]);
            end
          end
          if (last[(k + NA - 1) % NA] >= 0) begin
            checks++;
            if (i - last[(k + NA - 1) % NA] != 3) begin
              errors++;
              $display("FAIL delay2_spacing stage=%0d got=%0d want=3", k, i - last[(k + NA - 1) % NA]);
            end
          end
          last[k] = i;
        end
      end
    end
    checks++;
    if (pulses != 15) begin errors++; $display("FAIL delay2_pulses got=%0d want=15", pulses); end
  endtask

  task automatic test_delay_one_long();
    int run = 0, runs = 0, last0 = -1;
    en_a = 1'b1; delay_a = '0; delay_a[3*DW +: DW] = 4'd10;
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (full_a[3]) run++;
      else if (run > 0) begin
        runs++;
        checks++;
        if (run != 11) begin errors++; $display("FAIL long_hold got=%0d want=11", run); end
        run = 0;
      end
      if (aclk_a[0]) begin
        if (last0 >= 0) begin
          checks++;
          if (i - last0 != 16) begin errors++; $display("FAIL long_period got=%0d want=16", i - last0); end
        end
        last0 = i;
      end
    end
    checks++;
    if (runs != 3) begin errors++; $display("FAIL long_runs got=%0d want=3", runs); end
  endtask

  task automatic test_half_buffer();
    logic [NB-1:0] prev, seen;
    logic [NA-1:0] want_full, want_aclk;
    en_b = 1'b1; delay_b = '0;
    do_reset();
    seen = '0;
    for (int i = 1; i <= 24; i++) begin
      prev = full_b;
      tick();
      want_full = exp_full(1);
      want_aclk = exp_aclk(1, en_b);
      checks++;
      if ({2'b00, full_b} !== want_full || {2'b00, aclk_b} !== want_aclk) begin
        errors++;
        $display("FAIL hb_model cyc=%0d full=%b aclk=%b want full=%b aclk=%b",
                 i, full_b, aclk_b, want_full, want_aclk);
      end
      checks++;
      if ($countones(full_b) != TB) begin
        errors++; $display("FAIL hb_tokens cyc=%0d got=%0d want=%0d", i, $countones(full_b), TB);
      end
      checks++;
      if ((aclk_b & prev) !== '0) begin
        errors++; $display("FAIL hb_refill cyc=%0d aclk=%b prev_full=%b want no overlap", i, aclk_b, prev);
      end
      seen |= aclk_b;
    end
    checks++;
    if (seen !== 4'hF) begin errors++; $display("FAIL hb_all_pulse got=%b want=1111", seen); end
  endtask

  task automatic test_enable_freeze();
    bit found = 1'b0;
    en_a = 1'b1; delay_a = '0;
    do_reset();
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      found = (full_a === 6'b000100);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL freeze_reach got=%b want=000100", full_a); end
    en_a = 1'b0;
    #1;
    checks++;
    if (aclk_a !== '0) begin errors++; $display("FAIL freeze_mask got=%b want=0", aclk_a); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (aclk_a !== '0 || full_a !== 6'b000100) begin
        errors++; $display("FAIL freeze_hold cyc=%0d aclk=%b full=%b want 0/000100", i, aclk_a, full_a);
      end
    end
    en_a = 1'b1;
    tick();
    checks++;
    if (aclk_a !== 6'b001000 || full_a !== 6'b001000) begin
      errors++; $display("FAIL freeze_resume aclk=%b full=%b want 001000", aclk_a, full_a);
    end
  endtask

  task automatic test_async_reset();
    en_a = 1'b1; delay_a = '0;
    do_reset();
    repeat (3) tick();
    checks++;
    if (full_a !== 6'b001000) begin errors++; $display("FAIL areset_pre got=%b want=001000", full_a); end
    rst_async_n = 1'b0;
    #1;
    checks++;
    if (full_a !== 6'b000001 || aclk_a !== '0) begin
      errors++; $display("FAIL areset_a full=%b aclk=%b want 000001/0", full_a, aclk_a);
    end
    checks++;
    if (full_b !== 4'b0111 || aclk_b !== '0) begin
      errors++; $display("FAIL areset_b full=%b aclk=%b want 0111/0", full_b, aclk_b);
    end
`ifdef ARISCV_CTRL_LAP_CNT_EN
    checks++;
    if (laps_a !== 32'd0) begin errors++; $display("FAIL areset_laps got=%0d want=0", laps_a); end
`endif
    #3;
    rst_async_n = 1'b1;
    model_reset(0);
    model_reset(1);
    tick();
    checks++;
    if (aclk_a !== 6'b000010) begin errors++; $display("FAIL areset_restart got=%b want=000010", aclk_a); end
  endtask

  task automatic test_random();
    logic [NA-1:0] want_full, want_aclk;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en_a = ($urandom_range(99) < 85);
      en_b = ($urandom_range(99) < 85);
      if ($urandom_range(3) == 0)
        for (int k = 0; k < NA; k++)
          delay_a[k*DW +: DW] = ($urandom_range(9) == 0) ? 4'hF : DW'($urandom_range(3));
      if ($urandom_range(3) == 0)
        for (int k = 0; k < NB; k++)
          delay_b[k*DW +: DW] = ($urandom_range(9) == 0) ? 4'hF : DW'($urandom_range(3));
      tick();
      checks++;
      if ({full_a, aclk_a} !== {exp_full(0), exp_aclk(0, en_a)}) begin
        errors++;
        $display("FAIL rand_a cyc=%0d full=%b aclk=%b want full=%b aclk=%b",
                 i, full_a, aclk_a, exp_full(0), exp_aclk(0, en_a));
      end
      want_full = exp_full(1);
      want_aclk = exp_aclk(1, en_b);
      checks++;
      if ({2'b00, full_b} !== want_full || {2'b00, aclk_b} !== want_aclk) begin
        errors++;
        $display("FAIL rand_b cyc=%0d full=%b aclk=%b want full=%b aclk=%b",
                 i, full_b, aclk_b, want_full, want_aclk);
      end
`ifdef ARISCV_CTRL_LAP_CNT_EN
      checks++;
      if (laps_a !== m_laps[0] || laps_b !== m_laps[1]) begin
        errors++;
        $display("FAIL rand_laps cyc=%0d got=%0d/%0d want=%0d/%0d", i, laps_a, laps_b, m_laps[0], m_laps[1]);
      end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset(0);
    model_reset(1);
    test_reset();
    test_ring_zero();
    test_ring_delay2();
    test_delay_one_long();
    test_half_buffer();
    test_enable_freeze();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
